bcd_sum_display: RTL and testbench
==================================

# bcd_sum_display

Downstream consumer of the 16-bit 8421 BCD adder. Captures the adder's BCD sum `y` and carry `cout` on a `load` strobe and time-multiplexes the result onto five active-low common-anode 7-segment digits: four sum digits plus one carry digit. The displayed value changes only at frame boundaries, so a frame never shows a mix of old and new digits. Supports leading-zero blanking and flags non-BCD nibbles.

## Interface
- `LENGTH`, 16: BCD sum width. Fixed at 16 in this revision, giving 4 sum digits plus 1 carry digit (`NUM_DIGITS` = 5).
- `CLK_DIV`, 50000: clocks per digit slot. Must be ≥ 2.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: capture `y`/`cout` this cycle.
- `y` in 16: BCD sum from the adder; `y[3:0]` is the units digit.
- `cout` in 1: decimal carry out of the adder.
- `blank_lz` in 1: leading-zero blanking enable, sampled live.
- `seg` out 7: `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low; constant 1 (off).
- `an` out 5: digit enables, active-low; `an[0]` is the units digit, `an[4]` is the carry digit.
- `err` out 1: the displayed value contains a nibble > 9.
- `frame_done` out 1: one-cycle pulse when the scan wraps from digit 4 to digit 0.

## Operation
**Registers:** shadow `{cout,y}` plus a `pending` flag; display register `disp`; prescaler `pcnt` (0..CLK_DIV-1); scan index `idx` (0..4).
- **Load:** on `load`=1, the shadow register takes `{cout,y}` and `pending` is set to 1. If several loads arrive in one frame, the last one wins.
- **Tick:** asserted when `pcnt`==CLK_DIV-1. On each tick, `pcnt` returns to 0 and `idx` advances. The sequence is 0→1→2→3→4→0 and the scan never stops.
- **Wrap tick** (`idx`=4):
  - `frame_done` is pulsed.
  - If `pending`, then `disp` takes the shadow value and `pending` is cleared.
  - If `load` is also asserted on the wrap tick, the incoming `{cout,y}` goes directly into `disp`, and `pending` is left clear.
- **Digit decode:**
  - Values 0–9 use standard glyphs: "0"=7'h40, "1"=7'h79, "9"=7'h10.
  - Any nibble > 9 shows "E"=7'h06.
  - Digit 4 shows "1" if the carry bit is set, else "0".
- **Blanking** (`blank_lz`=1):
  - Digit k (k ≥ 1) is blanked when it and every higher digit are zero. The carry digit counts as zero when its carry bit is 0.
  - A blanked digit drives `an` all-ones and `seg`=7'h7F during its slot.
  - Digit 0 is never blanked.
  - An "E" nibble counts as nonzero.
- **`err`:** registered; 1 when any nibble of `disp` is > 9. Updates on the same edge as `disp`.

## Timing
- **Reset values:**
  - `seg`=7'h7F, `an`=5'h1F, `dp`=1, `err`=0, `frame_done`=0.
  - `disp`=0, shadow=0, `pending`=0, `pcnt`=0, `idx`=0.
- **After reset release:**
  - At the first rising edge, `an`=5'b11110 and `seg` shows digit 0 of `disp` ("0").
  - `pcnt` begins counting at that same edge.
- **Slot and frame length:** each slot lasts exactly CLK_DIV cycles; a frame is 5×CLK_DIV cycles.
- **Registered outputs:** `an`/`seg` are registered and change on the same edge as `idx`. `an` has exactly one bit low per slot, or none when the digit is blanked.
- **`frame_done`:** high for the single cycle that follows the edge where `idx` returns to 0.
- **Load latency:** a load becomes visible at the next wrap, i.e. the next digit-0 slot. Worst case is 5×CLK_DIV cycles.
- **Mid-frame reset:** everything returns to reset values immediately (asynchronous); any pending value is lost.
- **`blank_lz` changes:** take effect at the next slot boundary.

## Structure
- **Package `bcd_disp_pkg`:**
  - `NUM_DIGITS`=5.
  - Segment constants: `SEG_OFF`=7'h7F, `SEG_E`=7'h06, and glyphs 0–9.
  - Index typedef (3 bits).
- **Sub-module `bcd_seg_decode`:** combinational; 4-bit nibble → 7-bit active-low pattern, with > 9 mapped to `SEG_E`. Instantiated once, on the currently selected nibble.
- **Top level:** prescaler, scan counter, shadow/pending logic, blanking logic, output registers.

## Test plan
All scenarios use CLK_DIV=4.
1. **Reset:** hold `rst_n`=0, toggle the inputs → `seg`=7'h7F, `an`=5'h1F, `dp`=1, `err`=0, `frame_done`=0. Release reset → digit 0 shows "0" on the next edge, and `frame_done` pulses every 20 cycles.
2. **Normal sum:** `load` y=16'h6912, `cout`=0, `blank_lz`=1 → from the next wrap, slots show 2,1,9,6 with `an`=11110,11101,11011,10111, then slot 4 has `an`=11111.
3. **Carry out:** `load` y=16'h0000, `cout`=1, `blank_lz`=1 → slots show 0,0,0,0,"1"; none are blanked, because the carry digit is nonzero.
4. **Zero with blanking:** `load` y=0, `cout`=0, `blank_lz`=1 → only `an[0]` goes low, with `seg`=7'h40. With `blank_lz`=0 → all five digits show "0".
5. **Load timing:**
   - Load 16'h1111 at `idx`=1, then 16'h2222 at `idx`=3 → the display shows the old value until the wrap, then 2222 only.
   - A load coinciding with the wrap tick appears in that same new frame.
6. **Non-BCD and reset:**
   - `load` y=16'h00A3 → digit 1 shows 7'h06, `err`=1 from the wrap.
   - Then assert `rst_n`=0 mid-slot → outputs go to reset values immediately, and `err`=0.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the BCD sum display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 5;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;

  typedef logic [2:0] idx_t;
  typedef logic [3:0] nib_t;

  function automatic logic is_bad(nib_t n);
    return n > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Nibble to active-low 7-segment glyph.
// Non-BCD nibbles render as "E".
module bcd_seg_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // glyph lookup, anything above 9 falls to "E"
  always_comb begin
    seg = SEG_E;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_sum_display.sv
// Scans a captured BCD sum plus carry onto five
// multiplexed 7-segment digits, swapping values per frame.
module bcd_sum_display
  import bcd_disp_pkg::*;
#(
  parameter int LENGTH  = 16,
  parameter int CLK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LENGTH-1:0] y,
  input  logic              cout,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [4:0]        an,
  output logic              err,
  output logic              frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = LENGTH + 1;

  logic [PW-1:0] pcnt;
  idx_t          idx, idx_nxt;
  logic          tick, wrap;
  logic [DW-1:0] shadow, disp, disp_nxt;
  logic          pending, pending_nxt;
  logic          live;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic [4:0]    onehot;
  logic          blank, bad;
  logic [4:0]    nz, lead;

  assign dp   = 1'b1;
  assign tick = (pcnt == PW'(CLK_DIV - 1));
  assign wrap = tick && (idx == 3'd4);

  // next scan index
  always_comb begin
    idx_nxt = idx;
    if (wrap)      idx_nxt = 3'd0;
    else if (tick) idx_nxt = idx + 3'd1;
  end

  // frame-boundary swap of the shadow into the display
  always_comb begin
    disp_nxt    = disp;
    pending_nxt = pending;
    if (wrap) begin
      pending_nxt = 1'b0;
      if (load)         disp_nxt = {cout, y};
      else if (pending) disp_nxt = shadow;
    end else if (load) begin
      pending_nxt = 1'b1;
    end
  end

  // zero detection, leading-zero chain and bad-nibble flag
  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nz[k] = |disp_nxt[4*k +: 4];
      bad   = bad | is_bad(disp_nxt[4*k +: 4]);
    end
    nz[4]   = disp_nxt[LENGTH];
    lead    = '0;
    lead[4] = !nz[4];
    for (int k = 3; k >= 1; k--)
      lead[k] = lead[k+1] && !nz[k];
  end

  // select the digit that the next slot will show
  always_comb begin
    nib    = {3'b000, disp_nxt[LENGTH]};
    onehot = 5'b10000;
    blank  = blank_lz && lead[4];
    case (idx_nxt)
      3'd0: begin
        nib    = disp_nxt[3:0];
        onehot = 5'b00001;
        blank  = 1'b0;
      end
      3'd1: begin
        nib    = disp_nxt[7:4];
        onehot = 5'b00010;
        blank  = blank_lz && lead[1];
      end
      3'd2: begin
        nib    = disp_nxt[11:8];
        onehot = 5'b00100;
        blank  = blank_lz && lead[2];
      end
      3'd3: begin
        nib    = disp_nxt[15:12];
        onehot = 5'b01000;
        blank  = blank_lz && lead[3];
      end
      default: ;
    endcase
  end

  bcd_seg_decode u_dec (
    .nib (nib),
    .seg (glyph)
  );

  // prescaler and scan counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      idx  <= idx_nxt;
    end
  end

  // shadow capture, pending flag, display value and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      pending <= 1'b0;
      disp    <= '0;
      err     <= 1'b0;
    end else begin
      if (load) shadow <= {cout, y};
      pending <= pending_nxt;
      disp    <= disp_nxt;
      err     <= bad;
    end
  end

  // digit drive refreshes at slot starts and on the first edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live       <= 1'b0;
      seg        <= SEG_OFF;
      an         <= 5'h1F;
      frame_done <= 1'b0;
    end else begin
      live       <= 1'b1;
      frame_done <= wrap;
      if (tick || !live) begin
        an  <= blank ? 5'h1F : ~onehot;
        seg <= blank ? SEG_OFF : glyph;
      end
    end
  end

endmodule

// File: tb/tb_bcd_sum_display.sv
// Scoreboard bench for bcd_sum_display with CLK_DIV=4.
// Expected frames are queued by stimulus, checked by a monitor.
module tb_bcd_sum_display;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] y = '0;
  logic        cout = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [4:0]  an;
  logic        err;
  logic        frame_done;

  typedef struct packed {
    logic [4:0] an;
    logic [6:0] seg;
    logic       err;
  } slot_t;

  slot_t exp_q[$];
  int errs = 0;
  int checks = 0;

  bcd_sum_display #(
    .LENGTH  (16),
    .CLK_DIV (CD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .y          (y),
    .cout       (cout),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .err        (err),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // segs = {s4,s3,s2,s1,s0}; blanked digits expect an=1F, seg=7F
  task automatic push_frame(input logic [34:0] segs,
                            input logic [4:0]  blanked,
                            input logic        e);
    slot_t s;
    for (int k = 0; k < 5; k++) begin
      s.an  = blanked[k] ? 5'h1F : ~(5'b00001 << k);
      s.seg = blanked[k] ? 7'h7F : segs[7*k +: 7];
      s.err = e;
      exp_q.push_back(s);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 100);
    check("frame_done wait", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic settle();
    wait_frame();
    wait_frame();
    step();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic c);
    y    = v;
    cout = c;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // monitor: a queued frame is checked slot by slot from its start
  initial begin
    slot_t f[5];
    forever begin
      step();
      if (rst_n && frame_done && exp_q.size() >= 5) begin
        for (int k = 0; k < 5; k++) f[k] = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
          if (k > 0) begin
            repeat (CD) @(posedge clk);
            #1;
          end
          check($sformatf("an slot%0d", k), 32'(an), 32'(f[k].an));
          check($sformatf("seg slot%0d", k), 32'(seg), 32'(f[k].seg));
          check($sformatf("err slot%0d", k), 32'(err), 32'(f[k].err));
          check($sformatf("dp slot%0d", k), 32'(dp), 32'd1);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) begin
      step();
      load     = ~load;
      y        = 16'($urandom);
      cout     = ~cout;
      blank_lz = ~blank_lz;
    end
    step();
    check("rst seg", 32'(seg), 32'h7F);
    check("rst an", 32'(an), 32'h1F);
    check("rst dp", 32'(dp), 32'd1);
    check("rst err", 32'(err), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    load     = 1'b0;
    y        = '0;
    cout     = 1'b0;
    blank_lz = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("first an", 32'(an), 32'h1E);
    check("first seg", 32'(seg), 32'h40);
    n = 1;
    while (!frame_done && n < 100) begin
      step();
      n++;
    end
    check("first frame len", n, 20);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 100);
    check("frame period", n, 20);
    step();

    blank_lz = 1'b1;
    pulse_load(16'h6912, 1'b0);
    push_frame({7'h7F, 7'h02, 7'h10, 7'h79, 7'h24}, 5'b10000, 1'b0);
    settle();

    pulse_load(16'h0000, 1'b1);
    push_frame({7'h79, 7'h40, 7'h40, 7'h40, 7'h40}, 5'b00000, 1'b0);
    settle();

    pulse_load(16'h0000, 1'b0);
    push_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 5'b11110, 1'b0);
    settle();

    blank_lz = 1'b0;
    push_frame({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 5'b00000, 1'b0);
    settle();

    push_frame({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 5'b00000, 1'b0);
    wait_frame();
    repeat (4) step();
    pulse_load(16'h1111, 1'b0);
    repeat (7) step();
    pulse_load(16'h2222, 1'b0);
    push_frame({7'h40, 7'h24, 7'h24, 7'h24, 7'h24}, 5'b00000, 1'b0);
    wait_frame();
    wait_frame();
    step();

    repeat (18) step();
    blank_lz = 1'b1;
    push_frame({7'h7F, 7'h7F, 7'h30, 7'h19, 7'h12}, 5'b11000, 1'b0);
    pulse_load(16'h0345, 1'b0);
    check("wrap load frame_done", 32'(frame_done), 32'd1);
    wait_frame();
    step();

    pulse_load(16'h00A3, 1'b0);
    push_frame({7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h30}, 5'b11100, 1'b1);
    wait_frame();
    wait_frame();
    repeat (2) step();
    check("err before reset", 32'(err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst seg", 32'(seg), 32'h7F);
    check("midrst an", 32'(an), 32'h1F);
    check("midrst dp", 32'(dp), 32'd1);
    check("midrst err", 32'(err), 32'd0);
    check("midrst frame_done", 32'(frame_done), 32'd0);
    check("queue drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
